// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen-size defaults, command encodings and the
// rectangle engine state encoding.
package vga_pkg;

    localparam int unsigned X_SCREEN_DEF = 160;
    localparam int unsigned Y_SCREEN_DEF = 120;
    localparam int unsigned XW_DEF       = 8;
    localparam int unsigned YW_DEF       = 7;
    localparam int unsigned CW_DEF       = 3;

    localparam logic CMD_BOX  = 1'b0;
    localparam logic CMD_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_EMPTY,
        ST_DONE
    } plot_state_t;

endpackage

// File: rtl/rect_scanner.sv
// Row-major x/y scan counters over a latched rectangle, with last-pixel detect.
module rect_scanner #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_advance,
    input  logic [XW-1:0] i_x0,
    input  logic [YW-1:0] i_y0,
    input  logic [XW-1:0] i_ex,
    input  logic [YW-1:0] i_ey,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);

    logic [XW-1:0] x_q, x_d, x0_q, x0_d, ex_q, ex_d;
    logic [YW-1:0] y_q, y_d, ey_q, ey_d;

    // Load a new rectangle or step to the next pixel, wrapping x at the row end
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        x0_d = x0_q;
        ex_d = ex_q;
        ey_d = ey_q;
        if (i_load) begin
            x_d  = i_x0;
            y_d  = i_y0;
            x0_d = i_x0;
            ex_d = i_ex;
            ey_d = i_ey;
        end else if (i_advance) begin
            if (x_q == ex_q) begin
                x_d = x0_q;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Counter and bounds registers, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q  <= '0;
            y_q  <= '0;
            x0_q <= '0;
            ex_q <= '0;
            ey_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            x0_q <= x0_d;
            ex_q <= ex_d;
            ey_q <= ey_d;
        end
    end

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_last = (x_q == ex_q) && (y_q == ey_q);

endmodule

// File: rtl/box_plotter.sv
// VGA rectangle engine: accepts box / full-screen fill commands, clips them to
// the screen and scans the area one pixel per cycle into the pixel-write port.
module box_plotter
    import vga_pkg::*;
#(
    parameter int unsigned X_SCREEN = X_SCREEN_DEF,
    parameter int unsigned Y_SCREEN = Y_SCREEN_DEF,
    parameter int unsigned XW       = XW_DEF,
    parameter int unsigned YW       = YW_DEF,
    parameter int unsigned CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_cmd,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [XW-1:0] i_w,
    input  logic [YW-1:0] i_h,
    input  logic [CW-1:0] i_colour,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [CW-1:0] o_colour,
    output logic          o_plot,
    output logic          o_done
);

    localparam logic [XW:0] X_LIM = (XW+1)'(X_SCREEN);
    localparam logic [YW:0] Y_LIM = (YW+1)'(Y_SCREEN);

    plot_state_t   state_q, state_d;
    logic          ready_q, ready_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;
    logic [CW-1:0] colour_q, colour_d;

    logic [XW:0]   xs, ws, x_end;
    logic [YW:0]   ys, hs, y_end;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic          empty;
    logic          load, advance, last;

    // Normalise the command to origin/size and clip its end point to the screen
    always_comb begin
        if (i_cmd == CMD_FILL) begin
            xs = '0;
            ys = '0;
            ws = X_LIM;
            hs = Y_LIM;
        end else begin
            xs = {1'b0, i_x};
            ys = {1'b0, i_y};
            ws = {1'b0, i_w};
            hs = {1'b0, i_h};
        end
        x_end = xs + ws;
        if (x_end > X_LIM) x_end = X_LIM;
        y_end = ys + hs;
        if (y_end > Y_LIM) y_end = Y_LIM;
        ex    = XW'(x_end - 1'b1);
        ey    = YW'(y_end - 1'b1);
        empty = (ws == '0) || (hs == '0) || (xs >= X_LIM) || (ys >= Y_LIM);
    end

    // Next-state logic; registered outputs are decoded from the next state
    always_comb begin
        state_d  = state_q;
        colour_d = colour_q;
        load     = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (empty) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d  = ST_DRAW;
                        load     = 1'b1;
                        colour_d = i_colour;
                    end
                end
            end
            ST_DRAW: begin
                if (last) state_d = ST_DONE;
                else      advance = 1'b1;
            end
            ST_EMPTY: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        plot_d  = (state_d == ST_DRAW);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            colour_q <= colour_d;
        end
    end

    rect_scanner #(
        .XW (XW),
        .YW (YW)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .i_load    (load),
        .i_advance (advance),
        .i_x0      (XW'(xs)),
        .i_y0      (YW'(ys)),
        .i_ex      (ex),
        .i_ey      (ey),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_last    (last)
    );

    assign o_ready  = ready_q;
    assign o_plot   = plot_q;
    assign o_done   = done_q;
    assign o_colour = colour_q;

endmodule

// File: tb/tb_box_plotter.sv
// Self-checking bench for box_plotter: a pixel-list model built from the
// rectangle/clipping rules is compared against the DUT on every cycle.
module tb_box_plotter;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_valid;
    logic       o_ready;
    logic       i_cmd;
    logic [7:0] i_x, i_w;
    logic [6:0] i_y, i_h;
    logic [2:0] i_colour;
    logic [7:0] o_x;
    logic [6:0] o_y;
    logic [2:0] o_colour;
    logic       o_plot;
    logic       o_done;

    box_plotter #(
        .X_SCREEN (160),
        .Y_SCREEN (120),
        .XW       (8),
        .YW       (7),
        .CW       (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_cmd    (i_cmd),
        .i_x      (i_x),
        .i_y      (i_y),
        .i_w      (i_w),
        .i_h      (i_h),
        .i_colour (i_colour),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_colour (o_colour),
        .o_plot   (o_plot),
        .o_done   (o_done)
    );

    always #5 clk = ~clk;

    // cyc = cycle number of the period that follows the latest rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    pix_t q[$];
    int   last_x = 0, last_y = 0, last_c = 0;
    int   busy_lo = -10, busy_hi = -10, done_cyc = -10;

    function automatic bit model_ready(input int c);
        return !(c >= busy_lo && c <= busy_hi);
    endfunction

    // Expected pixel list for a command accepted at the edge ending cycle t
    task automatic build(input logic cmd, input int x, input int y, input int w,
                         input int h, input int c, input int t);
        int   x0, y0, ww, hh, n, neff;
        pix_t p;
        if (cmd) begin
            x0 = 0; y0 = 0; ww = 160; hh = 120;
        end else begin
            x0 = x; y0 = y; ww = w; hh = h;
        end
        n = 0;
        for (int yy = y0; yy < y0 + hh; yy++)
            for (int xx = x0; xx < x0 + ww; xx++)
                if (xx < 160 && yy < 120) begin
                    n++;
                    p.x = xx; p.y = yy; p.c = c; p.cyc = t + n;
                    q.push_back(p);
                end
        neff     = (n == 0) ? 1 : n;
        busy_lo  = t + 1;
        busy_hi  = t + neff + 1;
        done_cyc = t + neff + 1;
    endtask

    // ---------------- observation / compare ----------------
    bit chk_en = 0;
    int plot_cnt = 0, done_cnt = 0, done_seen = -1;
    int first_x = -1, first_y = -1, lastp_x = -1, lastp_y = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            bit   exp_plot;
            pix_t p;
            exp_plot = (q.size() > 0) && (q[0].cyc == cyc);
            check("plot", 32'(o_plot), 32'(exp_plot));
            if (exp_plot) begin
                p = q.pop_front();
                last_x = p.x; last_y = p.y; last_c = p.c;
            end
            check("x", 32'(o_x), last_x);
            check("y", 32'(o_y), last_y);
            check("colour", 32'(o_colour), last_c);
            check("done", 32'(o_done), 32'(cyc == done_cyc));
            check("ready", 32'(o_ready), 32'(model_ready(cyc)));
            if (o_plot) begin
                if (plot_cnt == 0) begin first_x = o_x; first_y = o_y; end
                plot_cnt++;
                lastp_x = o_x; lastp_y = o_y;
            end
            if (o_done) begin
                done_cnt++;
                done_seen = cyc;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic clear_obs();
        plot_cnt = 0; done_seen = -1;
        first_x = -1; first_y = -1; lastp_x = -1; lastp_y = -1;
    endtask

    // Present a command and hold it valid until the model says it is taken
    task automatic send(input logic cmd, input int x, input int y, input int w,
                        input int h, input int c, output int t);
        bit ok = 0;
        i_cmd = cmd; i_x = 8'(x); i_y = 7'(y); i_w = 8'(w); i_h = 7'(h);
        i_colour = 3'(c); i_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 30000; i++) begin
            if (model_ready(cyc)) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        if (!ok) begin
            $display("FAIL send_timeout: got 0 expected 1");
            n_fail++;
        end
        t = cyc;
        build(cmd, x, y, w, h, c, t);
        @(posedge clk); #2;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 30000; i++) begin
            if (cyc > busy_hi) begin ok = 1; break; end
            @(posedge clk); #2;
        end
        check("idle_timeout", 32'(ok), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, dcnt;
        reset = 1'b0; i_valid = 1'b0; i_cmd = 1'b0;
        i_x = '0; i_y = '0; i_w = '0; i_h = '0; i_colour = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 32'(o_ready), 1);
        check("rst_plot", 32'(o_plot), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_xy", {o_x, o_y}, 0);
        check("rst_colour", 32'(o_colour), 0);
        reset = 1'b1;
        chk_en = 1;
        @(posedge clk); #2;

        // 4x4 box at (10,20), colour 5
        clear_obs();
        send(1'b0, 10, 20, 4, 4, 5, t);
        wait_idle();
        check("box_count", plot_cnt, 16);
        check("box_first", {first_x[15:0], first_y[15:0]}, {16'd10, 16'd20});
        check("box_last", {lastp_x[15:0], lastp_y[15:0]}, {16'd13, 16'd23});
        check("box_done_t", done_seen - t, 17);

        // clipped box at (158,118)
        clear_obs();
        send(1'b0, 158, 118, 4, 4, 3, t);
        wait_idle();
        check("clip_count", plot_cnt, 4);
        check("clip_last", {lastp_x[15:0], lastp_y[15:0]}, {16'd159, 16'd119});
        check("clip_done_t", done_seen - t, 5);

        // zero width
        clear_obs();
        send(1'b0, 5, 5, 0, 4, 6, t);
        wait_idle();
        check("w0_count", plot_cnt, 0);
        check("w0_done_t", done_seen - t, 2);

        // origin off-screen
        clear_obs();
        send(1'b0, 170, 5, 4, 4, 2, t);
        wait_idle();
        check("x170_count", plot_cnt, 0);
        check("x170_done_t", done_seen - t, 2);

        // full-screen clear
        clear_obs();
        send(1'b1, 33, 44, 1, 1, 0, t);
        wait_idle();
        check("fill_count", plot_cnt, 19200);
        check("fill_first", {first_x[15:0], first_y[15:0]}, {16'd0, 16'd0});
        check("fill_last", {lastp_x[15:0], lastp_y[15:0]}, {16'd159, 16'd119});
        check("fill_done_t", done_seen - t, 19201);

        // second command held valid during DRAW
        clear_obs();
        dcnt = done_cnt;
        send(1'b0, 30, 40, 3, 2, 4, t);
        send(1'b0, 50, 60, 2, 2, 1, t2);
        wait_idle();
        check("hs_count", plot_cnt, 10);
        check("hs_accept_t", t2 - t, 8);
        check("hs_dones", done_cnt - dcnt, 2);

        // reset asserted while pixel 7 of a 4x4 box is on the port
        clear_obs();
        send(1'b0, 20, 30, 4, 4, 7, t);
        while (cyc < t + 7) begin @(posedge clk); #2; end
        dcnt = done_cnt;
        reset = 1'b0;
        @(posedge clk); #2;
        q.delete();
        last_x = 0; last_y = 0; last_c = 0;
        busy_lo = -10; busy_hi = -10; done_cyc = -10;
        check("abort_plot", 32'(o_plot), 0);
        check("abort_done", 32'(o_done), 0);
        check("abort_ready", 32'(o_ready), 1);
        check("abort_xyc", {o_x, o_y, o_colour}, 0);
        reset = 1'b1;
        check("abort_pixels", plot_cnt, 7);
        repeat (25) @(posedge clk);
        #2;
        check("abort_no_done", done_cnt - dcnt, 0);

        // engine recovers after abort
        clear_obs();
        send(1'b0, 0, 0, 2, 1, 6, t);
        wait_idle();
        check("recover_count", plot_cnt, 2);

        repeat (3) @(posedge clk);
        #2;
        check("model_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/box_plotter.md
# box_plotter

Parametrised VGA rectangle engine that supersedes the fixed 4x4 box plotter. It accepts a command over a valid/ready handshake and scans the rectangle row-major, one pixel per cycle, into the VGA adapter's pixel-write port. A command is either a box fill or a full-screen fill. Rectangles are clipped to the screen edges, and a one-cycle done pulse marks the end of each command.

## Interface

Parameters:
- X_SCREEN, 160, screen width in pixels
- Y_SCREEN, 120, screen height in pixels
- XW, 8, x coordinate width; X_SCREEN must be at most 2^XW
- YW, 7, y coordinate width; Y_SCREEN must be at most 2^YW
- CW, 3, colour width

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous, active-low
- i_valid, in, 1, command valid
- o_ready, out, 1, engine idle and able to accept a command
- i_cmd, in, 1, 0 = box, 1 = full-screen fill
- i_x, in, XW, box origin x (ignored for fill)
- i_y, in, YW, box origin y (ignored for fill)
- i_w, in, XW, box width in pixels (ignored for fill)
- i_h, in, YW, box height in pixels (ignored for fill)
- i_colour, in, CW, fill colour; fill with 0 is screen clear
- o_x, out, XW, pixel x
- o_y, out, YW, pixel y
- o_colour, out, CW, pixel colour
- o_plot, out, 1, pixel write enable
- o_done, out, 1, one-cycle pulse at command completion

## Operation

- FSM states:
  - IDLE: o_ready = 1. A command is accepted when i_valid & o_ready. On accept, latch origin, end point and colour, then go to DRAW or EMPTY.
  - DRAW: emits one pixel per cycle. After the last pixel, go to DONE.
  - EMPTY: the accepted command covers zero pixels. Go to DONE.
  - DONE: o_done = 1 for one cycle, then IDLE.
- Command latching:
  - Fill: origin (0,0), w = X_SCREEN, h = Y_SCREEN.
  - Box: origin (i_x, i_y), size (i_w, i_h).
- End-point arithmetic:
  - Compute in XW+1 and YW+1 bits so no wrap occurs.
  - ex = min(x + w, X_SCREEN) - 1
  - ey = min(y + h, Y_SCREEN) - 1
- EMPTY condition: w == 0, h == 0, x >= X_SCREEN, or y >= Y_SCREEN.
- Scan order: x runs from x0 to ex, then wraps to x0 with y incremented. The last pixel is (ex, ey).
- Outputs in DRAW: o_plot = 1, o_colour = the latched colour.
- Outputs outside DRAW: o_plot = 0. o_x, o_y and o_colour hold their last values.
- i_valid and command inputs are ignored while o_ready = 0.

## Timing

- All outputs are registered.
- Reset values: o_ready = 1, o_plot = 0, o_done = 0, o_x = 0, o_y = 0, o_colour = 0. State is IDLE and counters are cleared.
- Accept on edge T:
  - First pixel is valid on o_x/o_y/o_plot in cycle T+1.
  - For an N-pixel clipped area, the last pixel is in cycle T+N.
  - o_done is high in cycle T+N+1.
  - o_ready returns to 1 in cycle T+N+2.
- EMPTY command: o_done is high in cycle T+2, o_ready is 1 in cycle T+3, and no plot is issued.
- Back-to-back: i_valid held high while o_ready = 1 is accepted on that edge. This gives a minimum of 2 idle cycles between the last pixel of one command and the first pixel of the next.
- Reset asserted mid-draw: the command aborts on that edge and all outputs take reset values. No o_done is issued for the aborted command.
- Full-screen fill takes X_SCREEN*Y_SCREEN pixel cycles (19200 at defaults).

## Structure

- Shared package `vga_pkg` holds:
  - screen-size defaults
  - the command encodings CMD_BOX = 1'b0 and CMD_FILL = 1'b1
  - the FSM state encoding
- Sub-module `rect_scanner` holds the x/y counters with load, advance and last-pixel detect. The top level holds the FSM, the handshake, and the clipping arithmetic.

## Test plan

- **Box at (10,20), 4x4, colour 5:**
  - 16 plots, in order (10,20)…(13,20),(10,21)…(13,23), all colour 5.
  - Plots in cycles T+1..T+16, o_done in T+17.
- **Clipped box at (158,118), 4x4, colour 3:**
  - Exactly 4 plots: (158,118),(159,118),(158,119),(159,119).
  - o_done in T+5.
- **Fill with colour 0:**
  - 19200 plots, first (0,0), last (159,119), all colour 0.
  - o_done one cycle after the last plot.
- **Zero-size commands:** w = 0, and separately x = 170.
  - No plot is issued.
  - o_done in T+2.
- **Handshake:**
  - A second command asserted during DRAW is not accepted (o_ready = 0).
  - Holding it valid, it is accepted in the first IDLE cycle and drawn exactly once.
- **Reset mid-draw:** reset low at pixel 7 of a 4x4 box.
  - Next cycle o_plot = 0, o_done = 0, o_ready = 1, and o_x, o_y, o_colour are all 0.
  - No o_done pulse follows.
